// File: rtl/commit_ctrl_pkg.sv
// Shared defines header for the commit stage: ROB id width and 2-bit FSM encodings.
// Optional retired-instruction counter is enabled by defining COMMIT_CNT_EN.
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif
`ifndef COMMIT_ST_RUN
`define COMMIT_ST_RUN        2'd0
`define COMMIT_ST_STORE_WAIT 2'd1
`define COMMIT_ST_FLUSH      2'd2
`define COMMIT_ST_HALT       2'd3
`endif

package commit_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = `COMMIT_ST_RUN,
    ST_STORE_WAIT = `COMMIT_ST_STORE_WAIT,
    ST_FLUSH      = `COMMIT_ST_FLUSH,
    ST_HALT       = `COMMIT_ST_HALT
  } state_t;

endpackage

// File: rtl/commit_ctrl_if.sv
// ROB-head / commit bus between the reorder buffer side (master) and commit_ctrl (slave).
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

interface commit_ctrl_if;
  logic                  head_valid;
  logic                  head_done;
  logic [`ROB_WIDTH-1:0] head_rob_id;
  logic [4:0]            head_rd;
  logic [31:0]           head_val;
  logic                  head_is_store;
  logic                  head_is_halt;
  logic                  head_mispredict;
  logic [31:0]           head_target_pc;
  logic                  head_pop;
  logic                  store_req;
  logic                  store_ack;
  logic                  commit_ready;
  logic [4:0]            commit_reg_id;
  logic [31:0]           commit_val;
  logic [`ROB_WIDTH-1:0] commit_rob_id;
  logic                  clear;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  halted;

  modport master (
    output head_valid, head_done, head_rob_id, head_rd, head_val, head_is_store,
           head_is_halt, head_mispredict, head_target_pc, store_ack,
    input  head_pop, store_req, commit_ready, commit_reg_id, commit_val,
           commit_rob_id, clear, redirect_valid, redirect_pc, halted
  );

  modport slave (
    input  head_valid, head_done, head_rob_id, head_rd, head_val, head_is_store,
           head_is_halt, head_mispredict, head_target_pc, store_ack,
    output head_pop, store_req, commit_ready, commit_reg_id, commit_val,
           commit_rob_id, clear, redirect_valid, redirect_pc, halted
  );
endinterface

// File: rtl/commit_ctrl.sv
// In-order commit controller: retires the ROB head, sequences stores, flushes on mispredict, halts.
// Define COMMIT_CNT_EN to add the retired_cnt output.
module commit_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          rdy_in,
  commit_ctrl_if.slave  bus
`ifdef COMMIT_CNT_EN
  ,
  output logic [31:0]   retired_cnt
`endif
);
  import commit_ctrl_pkg::*;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t     state, state_nxt;
  logic [3:0] flush_cnt;
  logic       pop_c;
  logic       redir_c;
  logic [4:0] pop_rd_c;

  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    redir_c   = 1'b0;
    pop_rd_c  = bus.head_rd;
    if (rdy_in) begin
      unique case (state)
        ST_RUN: begin
          if (bus.head_valid && bus.head_done) begin
            if (bus.head_is_store) begin
              state_nxt = ST_STORE_WAIT;
            end else begin
              pop_c = 1'b1;
              // halt outranks mispredict: no flush, no redirect
              if (bus.head_is_halt) begin
                state_nxt = ST_HALT;
              end else if (bus.head_mispredict) begin
                state_nxt = ST_FLUSH;
                redir_c   = 1'b1;
              end
            end
          end
        end
        ST_STORE_WAIT: begin
          if (bus.store_ack) begin
            pop_c     = 1'b1;
            pop_rd_c  = '0;
            state_nxt = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt <= 4'd1) state_nxt = ST_RUN;
        end
        ST_HALT: state_nxt = ST_HALT;
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  assign bus.head_pop = pop_c;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
    end else if (rdy_in) begin
      state <= state_nxt;
      // flush_cnt holds the number of clear cycles still to run, including the current one
      if (state != ST_FLUSH && state_nxt == ST_FLUSH) flush_cnt <= FLUSH_INIT;
      else if (state == ST_FLUSH)                    flush_cnt <= flush_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus.commit_ready   <= 1'b0;
      bus.commit_reg_id  <= '0;
      bus.commit_val     <= '0;
      bus.commit_rob_id  <= '0;
      bus.clear          <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.store_req      <= 1'b0;
      bus.halted         <= 1'b0;
    end else if (rdy_in) begin
      bus.commit_ready   <= pop_c;
      if (pop_c) begin
        bus.commit_reg_id <= pop_rd_c;
        bus.commit_val    <= bus.head_val;
        bus.commit_rob_id <= bus.head_rob_id;
      end
      bus.clear          <= (state_nxt == ST_FLUSH);
      bus.redirect_valid <= redir_c;
      if (redir_c) bus.redirect_pc <= bus.head_target_pc;
      bus.store_req      <= (state_nxt == ST_STORE_WAIT);
      bus.halted         <= (state_nxt == ST_HALT);
    end
  end

`ifdef COMMIT_CNT_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)            retired_cnt <= '0;
    else if (rdy_in && pop_c) retired_cnt <= retired_cnt + 32'd1;
  end
`endif

endmodule
